// File: rtl/spi_frame_ctrl.sv
// Packs the SPI byte stream into 24-bit GRB pixels, writes them to the pixel RAM
// and launches the NeoPixel transmitter at frame end; frames seen while it is busy are dropped.
module spi_frame_ctrl #(
    parameter int MAX_PIXELS = 64,
    parameter int ADDR_W     = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              START,
    input  logic              READY,
    input  logic [7:0]        DATA,
    input  logic              END,
    input  logic              TX_BUSY,
    output logic              PIX_WE,
    output logic [ADDR_W-1:0] PIX_ADDR,
    output logic [23:0]       PIX_DATA,
    output logic              TX_START,
    output logic [ADDR_W:0]   TX_COUNT,
    output logic              FRAME_ERR,
    output logic              FRAME_DROP,
    output logic [1:0]        dbg_state_o
);

    // START/READY/END are single-cycle strobes from the SPI slave and are always
    // consumed in the cycle they appear; there is no backpressure path.
    typedef enum logic [1:0] {IDLE, RECV, DISCARD, LAUNCH} state_t;

    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_PIXELS);
    localparam logic [ADDR_W:0] ONE_CNT = (ADDR_W+1)'(1);

    state_t          state_q;
    logic [ADDR_W:0] idx_q, idx_d;
    logic [1:0]      phase_q, phase_d;
    logic [7:0]      b0_q, b1_q;
    logic            triple_done;
    logic            room;

    assign dbg_state_o = state_q;

    // Byte path is evaluated before END so a READY coinciding with END is counted.
    always_comb begin
        triple_done = READY && (phase_q == 2'd2);
        room        = (idx_q < MAX_CNT);
        idx_d       = idx_q;
        if (triple_done && room) idx_d = idx_q + ONE_CNT;
        phase_d = phase_q;
        if (READY) phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            phase_q    <= '0;
            b0_q       <= '0;
            b1_q       <= '0;
            PIX_WE     <= 1'b0;
            PIX_ADDR   <= '0;
            PIX_DATA   <= '0;
            TX_START   <= 1'b0;
            TX_COUNT   <= '0;
            FRAME_ERR  <= 1'b0;
            FRAME_DROP <= 1'b0;
        end else begin
            PIX_WE   <= 1'b0;
            TX_START <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (START) begin
                        if (!TX_BUSY) begin
                            idx_q      <= '0;
                            phase_q    <= '0;
                            FRAME_ERR  <= 1'b0;
                            FRAME_DROP <= 1'b0;
                            state_q    <= RECV;
                        end else begin
                            FRAME_DROP <= 1'b1;
                            state_q    <= DISCARD;
                        end
                    end
                end
                RECV: begin
                    if (READY) begin
                        phase_q <= phase_d;
                        idx_q   <= idx_d;
                        if (phase_q == 2'd0) b0_q <= DATA;
                        if (phase_q == 2'd1) b1_q <= DATA;
                        if (triple_done) begin
                            if (room) begin
                                PIX_WE   <= 1'b1;
                                PIX_ADDR <= idx_q[ADDR_W-1:0];
                                PIX_DATA <= {b0_q, b1_q, DATA};
                            end else begin
                                FRAME_ERR <= 1'b1;
                            end
                        end
                    end
                    if (END) begin
                        phase_q <= '0;
                        if (phase_d != 2'd0) FRAME_ERR <= 1'b1;
                        if (idx_d == '0) begin
                            state_q <= IDLE;
                        end else if (!TX_BUSY) begin
                            // Transmitter already free: launch straight away, LAUNCH only waits out TX_BUSY.
                            TX_START <= 1'b1;
                            TX_COUNT <= idx_d;
                            state_q  <= IDLE;
                        end else begin
                            state_q <= LAUNCH;
                        end
                    end else if (START) begin
                        FRAME_ERR <= 1'b1;
                        if (!TX_BUSY) begin
                            idx_q      <= '0;
                            phase_q    <= '0;
                            FRAME_DROP <= 1'b0;
                            state_q    <= RECV;
                        end else begin
                            FRAME_DROP <= 1'b1;
                            state_q    <= DISCARD;
                        end
                    end
                end
                DISCARD: begin
                    if (END) state_q <= IDLE;
                end
                LAUNCH: begin
                    if (!TX_BUSY) begin
                        TX_START <= 1'b1;
                        TX_COUNT <= idx_q;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Bench for spi_frame_ctrl: directed frames from the test plan followed by random
// frames, checked against a byte/pixel-level model and a write scoreboard.
module tb_spi_frame_ctrl;

    localparam int MAXP = 4;
    localparam int AW   = 2;
    localparam int W    = AW + 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          START = 1'b0;
    logic          READY = 1'b0;
    logic [7:0]    DATA = 8'h00;
    logic          END = 1'b0;
    logic          TX_BUSY = 1'b0;
    logic          PIX_WE;
    logic [AW-1:0] PIX_ADDR;
    logic [23:0]   PIX_DATA;
    logic          TX_START;
    logic [AW:0]   TX_COUNT;
    logic          FRAME_ERR;
    logic          FRAME_DROP;
    logic [1:0]    dbg_state;

    spi_frame_ctrl #(.MAX_PIXELS(MAXP), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .START(START), .READY(READY), .DATA(DATA),
        .END(END), .TX_BUSY(TX_BUSY), .PIX_WE(PIX_WE), .PIX_ADDR(PIX_ADDR),
        .PIX_DATA(PIX_DATA), .TX_START(TX_START), .TX_COUNT(TX_COUNT),
        .FRAME_ERR(FRAME_ERR), .FRAME_DROP(FRAME_DROP), .dbg_state_o(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- counters and scoreboard ----------------
    int n_checks = 0;
    int n_fail = 0;
    int exp_launches = 0;
    int seen_launches = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;

    // ---------------- reference model ----------------
    bit         m_in_frame, m_discard, m_pending, m_err, m_drop;
    int         m_pix, m_count;
    logic [7:0] m_part[$];
    bit         exp_we, exp_launch;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_err"}, 32'(FRAME_ERR), 32'(m_err));
        check({tag, "_drop"}, 32'(FRAME_DROP), 32'(m_drop));
        check({tag, "_count"}, 32'(TX_COUNT), 32'(m_count));
    endtask

    task automatic model_reset();
        m_in_frame = 0; m_discard = 0; m_pending = 0;
        m_err = 0; m_drop = 0; m_pix = 0; m_count = 0;
        m_part.delete();
        exp_q.delete();
    endtask

    task automatic model_start();
        bit restart;
        if (m_discard || m_pending) return;
        restart = m_in_frame;
        if (!TX_BUSY) begin
            m_err = restart; m_drop = 0; m_in_frame = 1; m_pix = 0;
            m_part.delete();
        end else begin
            m_err = m_err | restart; m_drop = 1; m_in_frame = 0; m_discard = 1;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        exp_we = 0;
        if (!m_in_frame) return;
        m_part.push_back(b);
        if (m_part.size() == 3) begin
            if (m_pix < MAXP) begin
                exp_q.push_back({AW'(m_pix), m_part[0], m_part[1], m_part[2]});
                exp_we = 1;
                m_pix++;
            end else begin
                m_err = 1;
            end
            m_part.delete();
        end
    endtask

    task automatic model_end();
        exp_launch = 0;
        if (m_in_frame) begin
            if (m_part.size() != 0) m_err = 1;
            m_part.delete();
            m_in_frame = 0;
            if (m_pix > 0) begin
                if (!TX_BUSY) begin
                    exp_launch = 1; m_count = m_pix; exp_launches++;
                end else begin
                    m_pending = 1;
                end
            end
        end else if (m_discard) begin
            m_discard = 0;
        end
    endtask

    // ---------------- driver tasks (entered at posedge + 1) ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_start();
        model_start();
        START = 1'b1;
        @(posedge clk); #1;
        START = 1'b0;
        check("start_txs", 32'(TX_START), 32'd0);
        check_flags("start");
    endtask

    task automatic send_byte(input logic [7:0] b, input bit with_end);
        model_byte(b);
        if (with_end) model_end();
        READY = 1'b1; DATA = b; END = with_end;
        @(posedge clk); #1;
        READY = 1'b0; END = 1'b0;
        check("byte_we", 32'(PIX_WE), 32'(exp_we));
        check("byte_txs", 32'(TX_START), 32'(with_end && exp_launch));
        check_flags("byte");
    endtask

    task automatic send_end();
        model_end();
        END = 1'b1;
        @(posedge clk); #1;
        END = 1'b0;
        check("end_txs", 32'(TX_START), 32'(exp_launch));
        check_flags("end");
    endtask

    task automatic release_busy(input int hold);
        repeat (hold) begin
            @(posedge clk); #1;
            check("launch_hold", 32'(TX_START), 32'd0);
        end
        TX_BUSY = 1'b0;
        if (m_pending) begin
            m_pending = 0; m_count = m_pix; exp_launches++;
            @(posedge clk); #1;
            check("launch_rel", 32'(TX_START), 32'd1);
            check_flags("launch");
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        START = 1'b0; READY = 1'b0; END = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            check("rst_ctl", {28'd0, PIX_WE, TX_START, FRAME_ERR, FRAME_DROP}, 32'd0);
            check("rst_data", {3'd0, PIX_ADDR, PIX_DATA, TX_COUNT}, 32'd0);
        end
        model_reset();
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic send_bytes(input logic [7:0] b0, input int n, input logic [7:0] step);
        logic [7:0] b;
        b = b0;
        for (int i = 0; i < n; i++) begin
            send_byte(b, 1'b0);
            b = b + step;
        end
    endtask

    // ---------------- monitor: write scoreboard and launch counter ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (PIX_WE === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_we", {6'd0, PIX_ADDR, PIX_DATA}, 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pix_addr_data", {6'd0, PIX_ADDR, PIX_DATA}, {6'd0, mon_e});
                end
            end
            if (TX_START === 1'b1) seen_launches++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        #1;
        do_reset(3);

        // Two-pixel frame
        send_start();
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
        send_byte(8'hAA, 0); send_byte(8'h55, 0); send_byte(8'h66, 0);
        send_end();
        check("two_pix_count", 32'(TX_COUNT), 32'd2);
        check("two_pix_err", 32'(FRAME_ERR), 32'd0);
        idle(2);

        // Partial triple
        send_start();
        send_bytes(8'h01, 4, 8'h01);
        send_end();
        check("partial_count", 32'(TX_COUNT), 32'd1);
        check("partial_err", 32'(FRAME_ERR), 32'd1);
        idle(2);

        // Overflow past MAXP pixels
        send_start();
        send_bytes(8'h40, 15, 8'h03);
        send_end();
        check("ovf_count", 32'(TX_COUNT), 32'd4);
        check("ovf_err", 32'(FRAME_ERR), 32'd1);
        idle(2);

        // Busy rejection
        TX_BUSY = 1'b1;
        send_start();
        send_bytes(8'hC0, 6, 8'h01);
        send_end();
        check("busy_drop", 32'(FRAME_DROP), 32'd1);
        TX_BUSY = 1'b0;
        idle(2);

        // Restart without END, then empty frame
        send_start();
        send_bytes(8'h21, 3, 8'h01);
        send_start();
        send_bytes(8'h31, 3, 8'h01);
        send_end();
        check("restart_err", 32'(FRAME_ERR), 32'd1);
        check("restart_count", 32'(TX_COUNT), 32'd1);
        idle(1);
        send_start();
        send_end();
        check("empty_flags", {30'd0, FRAME_ERR, FRAME_DROP}, 32'd0);
        idle(2);

        // Mid-frame reset
        send_start();
        send_bytes(8'h70, 2, 8'h01);
        do_reset(2);
        send_start();
        send_bytes(8'h90, 3, 8'h01);
        send_end();
        check("post_rst_count", 32'(TX_COUNT), 32'd1);
        idle(2);

        // Launch held off by TX_BUSY
        send_start();
        send_bytes(8'hE0, 6, 8'h01);
        TX_BUSY = 1'b1;
        send_end();
        check("pending_nolaunch", 32'(TX_START), 32'd0);
        release_busy(4);
        check("pending_count", 32'(TX_COUNT), 32'd2);
        idle(2);

        // READY and END in the same cycle
        send_start();
        send_bytes(8'h05, 5, 8'h07);
        send_byte(8'hFE, 1);
        check("rdy_end_count", 32'(TX_COUNT), 32'd2);
        idle(2);

        // Random frames
        for (int f = 0; f < 150; f++) begin
            int  nb;
            bit  joined;
            nb     = $urandom_range(0, 14);
            joined = (nb > 0) && ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) send_byte(8'($urandom), 0);
            if ($urandom_range(0, 5) == 0) send_end();
            TX_BUSY = ($urandom_range(0, 5) == 0);
            send_start();
            TX_BUSY = 1'b0;
            for (int i = 0; i < nb; i++) begin
                idle($urandom_range(0, 2));
                if (i == nb / 2 && $urandom_range(0, 9) == 0) send_start();
                if (i == nb - 1 && joined) begin
                    TX_BUSY = ($urandom_range(0, 4) == 0);
                    send_byte(8'($urandom), 1);
                end else begin
                    send_byte(8'($urandom), 0);
                end
            end
            if (!joined) begin
                TX_BUSY = ($urandom_range(0, 4) == 0);
                send_end();
            end
            if (m_pending) release_busy($urandom_range(0, 3));
            TX_BUSY = 1'b0;
            idle($urandom_range(1, 3));
        end

        idle(3);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("launch_total", 32'(seen_launches), 32'(exp_launches));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_frame_ctrl.md
# spi_frame_ctrl

Frame controller between `SPI_rx_slave` and the NeoPixel transmitter. It consumes the byte stream and the START/END framing strobes from the SPI slave, and packs every 3 bytes into one 24-bit GRB pixel. Pixels are written sequentially into the pixel RAM. On frame end it launches the transmitter with the pixel count. Frames that arrive while the transmitter is busy are rejected whole, so the RAM is never rewritten during a transmit.

## Interface
- `MAX_PIXELS`, default 64: pixel RAM depth. Must be at least 1.
- `ADDR_W`, default 6: pixel address width, equal to clog2(`MAX_PIXELS`).

Ports, clock and reset first:
- `clk` in, 1: system clock. This is the same clock that drives `SPI_rx_slave`.
- `rst_n` in, 1: reset. It is synchronous and active-low.
- `START` in, 1: one-cycle pulse from the SPI slave when SSEL is asserted.
- `READY` in, 1: one-cycle pulse from the SPI slave when `DATA` holds a complete byte.
- `DATA` in, 8: received byte. It is valid only while `READY` is high.
- `END` in, 1: one-cycle pulse from the SPI slave when SSEL is deasserted.
- `TX_BUSY` in, 1: high while the NeoPixel transmitter is reading the RAM and shifting out pixels.
- `PIX_WE` out, 1: pixel RAM write enable, a one-cycle pulse.
- `PIX_ADDR` out, `ADDR_W`: pixel RAM write address.
- `PIX_DATA` out, 24: pixel value {G,R,B}. The first byte of the triple goes to [23:16].
- `TX_START` out, 1: one-cycle launch pulse to the transmitter.
- `TX_COUNT` out, `ADDR_W`+1: number of pixels to send. It is valid while `TX_START` is high and is held afterwards.
- `FRAME_ERR` out, 1: sticky error flag. It is cleared on the next accepted START.
- `FRAME_DROP` out, 1: sticky drop flag. It is cleared on the next accepted START.

## Operation
The state machine has four states: IDLE, RECV, DISCARD, LAUNCH.

- **IDLE**
  - `START` with `TX_BUSY`=0: clear the pixel index, byte phase, `FRAME_ERR` and `FRAME_DROP`, then go to RECV.
  - `START` with `TX_BUSY`=1: set `FRAME_DROP` and go to DISCARD.
  - `READY` or `END` without a preceding `START`: ignored.
- **RECV**
  - Each `READY` loads `DATA` into byte slot `phase` (0, 1 or 2), then `phase` advances modulo 3.
  - On the third byte:
    - If index < `MAX_PIXELS`: write `PIX_DATA`={b0,b1,b2} at `PIX_ADDR`=index, then increment index.
    - Otherwise (overflow): drop the pixel, set `FRAME_ERR`, leave index saturated at `MAX_PIXELS`.
  - `END` with phase≠0 (partial triple): discard the partial bytes, set `FRAME_ERR`, then continue as for a normal end.
  - `END` with index>0: go to LAUNCH.
  - `END` with index=0: go to IDLE without launching.
  - `START` while in RECV (END was missing): set `FRAME_ERR`, then restart the frame as from IDLE. `TX_BUSY` is rechecked at this point.
- **DISCARD**: ignore every `READY` until `END`, then go to IDLE. A `START` here stays in DISCARD.
- **LAUNCH**
  - Pulse `TX_START` for one cycle with `TX_COUNT`=index, then go to IDLE.
  - If `TX_BUSY` is still high on entry, hold in LAUNCH until it falls.
  - Inputs are ignored while in LAUNCH.
- **Simultaneous `READY` and `END` in one cycle**: the byte is processed first, then the end.
- **Simultaneous `END` and `START` in one cycle**: the end is processed. The `START` is lost, which is acceptable because SSEL cannot toggle that fast.
- **Reset**, including mid-frame:
  - State returns to IDLE; index and phase are cleared.
  - All outputs go to 0: `PIX_WE`, `PIX_ADDR`, `PIX_DATA`, `TX_START`, `TX_COUNT`, `FRAME_ERR`, `FRAME_DROP`.
  - RAM contents are untouched.

## Timing
- All outputs are registered.
- `PIX_WE` rises 1 cycle after the `READY` of the third byte. `PIX_ADDR` and `PIX_DATA` are valid in that same cycle and held until the next write.
- `TX_START` rises 1 cycle after `END` if `TX_BUSY`=0. Otherwise it rises 1 cycle after `TX_BUSY` falls.
- Back-to-back `READY` pulses are accepted on every clock. There is no backpressure to the SPI slave.
- `FRAME_ERR` and `FRAME_DROP` set 1 cycle after the causing event.
- Index arithmetic is `ADDR_W`+1 bits wide, so the value `MAX_PIXELS` is representable and never wraps.

## Test plan
- **Two-pixel frame.** Stimulus: reset, then START, bytes 11 22 33 AA 55 66, END. Required response:
  - `PIX_WE` pulses at addresses 0 and 1 with data 112233 and AA5566.
  - `TX_START` pulses 1 cycle after END with `TX_COUNT`=2.
  - `FRAME_ERR`=0.
- **Partial triple.** Stimulus: START, bytes 01 02 03 04, END. Required response:
  - One write: 010203 at address 0.
  - `TX_COUNT`=1 and `FRAME_ERR`=1.
- **Overflow with `MAX_PIXELS`=4.** Stimulus: 15 bytes. Required response:
  - Writes at addresses 0–3 only.
  - `TX_COUNT`=4 and `FRAME_ERR`=1.
- **Busy rejection.** Stimulus: hold `TX_BUSY`=1, then START, 6 bytes, END. Required response:
  - No `PIX_WE` and no `TX_START`.
  - `FRAME_DROP`=1.
- **Restart and empty frame.** Stimulus: START, 3 bytes, START, 3 bytes, END. Required response:
  - Both writes go to address 0.
  - `FRAME_ERR`=1 and `TX_COUNT`=1.
  - A following START then END gives no `TX_START` and clears the flags.
- **Mid-frame reset.** Stimulus: `rst_n`=0 after 2 bytes, then release reset, then a full 3-byte frame. Required response:
  - All outputs read 0 during reset.
  - The new frame writes at address 0 with `TX_COUNT`=1.
